// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a length-limited burst from a show-ahead FIFO
// into a registered valid/ready output stage.
package fifo_burst_reader_pkg;
  typedef logic [31:0] uint32_t;
  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH
  } state_t;
endpackage

module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter type fifo_t = uint32_t,
  parameter int MAX_BURST = 256,
  localparam int LEN_W = $clog2(MAX_BURST) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             fifo_empty,
  input  fifo_t            fifo_data,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output fifo_t            out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] clip_len;
  logic             done_q;
  logic             cmd_fire;
  logic             out_fire;
  logic             pop;
  logic             last_fire;

  assign clip_len = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign cmd_fire = cmd_valid && cmd_ready;
  assign out_fire = out_valid && out_ready;

  // A pop refills the output register, so it may only happen
  // when that register is empty or being drained this cycle.
  assign pop = rst_n
            && (state == READ)
            && (remaining != '0)
            && !fifo_empty
            && (!out_valid || out_ready);

  assign last_fire = (state == FLUSH) && out_fire && out_last;

  assign fifo_pop  = pop;
  assign cmd_ready = (state == IDLE);
  assign busy      = rst_n && (state != IDLE);
  assign done      = rst_n && (done_q || last_fire);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      done_q    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      done_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            remaining <= clip_len;
            if (clip_len != '0) begin
              state <= READ;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (pop) begin
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (last_fire) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (pop) begin
        out_data  <= fifo_data;
        out_valid <= 1'b1;
        out_last  <= (remaining == ONE);
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: randomized and directed checks of the burst
// reader against a queue-based reference model.
module tb_fifo_burst_reader;
  import fifo_burst_reader_pkg::*;

  localparam int MAXB = 256;
  localparam int LW = $clog2(MAXB) + 1;

  typedef struct {
    logic [31:0] d;
    bit          last;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          fifo_empty;
  uint32_t       fifo_data;
  logic          fifo_pop;
  logic          out_valid;
  logic          out_ready;
  uint32_t       out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  fifo_burst_reader #(
    .fifo_t(uint32_t),
    .MAX_BURST(MAXB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len(cmd_len),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_pop(fifo_pop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // bench-side FIFO and reference model
  logic [31:0] fifo_q[$];
  bit          m_busy = 0;
  bit          m_zero = 0;
  int          m_left = 0;
  beat_t       slot[$];
  bit          pop_seen = 0;
  int          rdy_mode = 0;

  // observation logs
  int          cyc = 0;
  int          pop_cnt, beat_cnt, done_cnt, busy_cnt, last_cnt;
  int          pop_cyc[$];
  int          beat_cyc[$];
  int          done_cyc[$];
  logic [31:0] beat_d[$];
  bit          beat_l[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic sync_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 32'h0 : fifo_q[0];
  endtask

  task automatic push(input logic [31:0] v);
    fifo_q.push_back(v);
    sync_fifo();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_seen = 0;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
    sync_fifo();
  endtask

  task automatic clr_logs();
    pop_cnt = 0;
    beat_cnt = 0;
    done_cnt = 0;
    busy_cnt = 0;
    last_cnt = 0;
    pop_cyc.delete();
    beat_cyc.delete();
    done_cyc.delete();
    beat_d.delete();
    beat_l.delete();
  endtask

  task automatic send_cmd(input int len);
    cmd_valid = 1'b1;
    cmd_len = LW'(len);
    tick();
    cmd_valid = 1'b0;
    cmd_len = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((m_busy || m_zero) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", {63'b0, m_busy}, 64'd0);
  endtask

  // per-cycle compare and model step
  always @(negedge clk) begin
    bit exp_pop;
    bit exp_done;
    bit hs;
    bit lastdone;
    int l;
    cyc++;
    exp_pop = rst_n && m_busy && (m_left > 0) && (fifo_q.size() > 0)
           && (slot.size() == 0 || out_ready);
    exp_done = rst_n && (m_zero ||
               (slot.size() > 0 && slot[0].last && out_ready));
    chk("fifo_pop", fifo_pop, exp_pop);
    chk("busy", busy, rst_n && m_busy);
    chk("done", done, exp_done);
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("out_valid", out_valid, slot.size() > 0);
    if (slot.size() > 0) begin
      chk("out_data", out_data, slot[0].d);
      chk("out_last", out_last, slot[0].last);
    end

    if (fifo_pop) begin
      pop_cnt++;
      pop_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      beat_cnt++;
      beat_d.push_back(out_data);
      beat_l.push_back(out_last);
      beat_cyc.push_back(cyc);
      if (out_last) last_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    if (busy) busy_cnt++;
    pop_seen = fifo_pop;

    if (!rst_n) begin
      m_busy = 0;
      m_zero = 0;
      m_left = 0;
      slot.delete();
    end else begin
      hs = (slot.size() > 0) && out_ready;
      lastdone = hs && slot[0].last;
      m_zero = 0;
      if (!m_busy) begin
        if (cmd_valid) begin
          l = (int'(cmd_len) > MAXB) ? MAXB : int'(cmd_len);
          if (l == 0) m_zero = 1;
          else begin
            m_busy = 1;
            m_left = l;
          end
        end
      end else begin
        if (exp_pop) begin
          slot.delete();
          slot.push_back('{fifo_q[0], m_left == 1});
          m_left--;
        end else if (hs) begin
          slot.delete();
        end
        if (lastdone) m_busy = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp4[4];
    int n;
    int len;
    int pushed;

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_len = '0;
    out_ready = 1'b1;
    fifo_empty = 1'b1;
    fifo_data = '0;
    clr_logs();
    repeat (3) tick();

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_pop", fifo_pop, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1);

    // full-rate drain
    exp4[0] = 32'h0000_00A0;
    exp4[1] = 32'h0000_00B0;
    exp4[2] = 32'h0000_00C0;
    exp4[3] = 32'h0000_00D0;
    for (int i = 0; i < 4; i++) push(exp4[i]);
    rdy_mode = 0;
    clr_logs();
    send_cmd(4);
    wait_idle(50);
    chk("drain_pops", pop_cnt, 4);
    chk("drain_beats", beat_cnt, 4);
    if (pop_cyc.size() == 4)
      chk("drain_pop_span", pop_cyc[3] - pop_cyc[0], 3);
    if (beat_cyc.size() == 4) begin
      chk("drain_beat_span", beat_cyc[3] - beat_cyc[0], 3);
      chk("drain_first_latency", beat_cyc[0] - pop_cyc[0], 1);
      for (int i = 0; i < 4; i++) begin
        chk("drain_data", beat_d[i], exp4[i]);
        chk("drain_last", beat_l[i], i == 3);
      end
      if (done_cyc.size() == 1)
        chk("drain_done_cycle", done_cyc[0], beat_cyc[3]);
    end
    chk("drain_done_cnt", done_cnt, 1);
    tick();
    chk("drain_cmd_ready", cmd_ready, 1);

    // backpressure
    push(32'h11);
    push(32'h22);
    push(32'h33);
    rdy_mode = 2;
    tick();
    clr_logs();
    send_cmd(3);
    repeat (6) tick();
    chk("bp_pops", pop_cnt, 1);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 32'h11);
    rdy_mode = 0;
    wait_idle(50);
    chk("bp_total_pops", pop_cnt, 3);
    chk("bp_beats", beat_cnt, 3);
    if (beat_d.size() == 3) begin
      chk("bp_d0", beat_d[0], 32'h11);
      chk("bp_d2", beat_d[2], 32'h33);
    end
    chk("bp_done", done_cnt, 1);

    // empty stall
    tick();
    send_cmd(2);
    clr_logs();
    repeat (10) tick();
    chk("stall_pops", pop_cnt, 0);
    chk("stall_busy_cycles", busy_cnt, 10);
    push(32'h5A5A_0001);
    push(32'h5A5A_0002);
    wait_idle(50);
    chk("stall_beats", beat_cnt, 2);
    chk("stall_done", done_cnt, 1);
    chk("stall_fifo_left", fifo_q.size(), 0);

    // zero length
    tick();
    clr_logs();
    send_cmd(0);
    repeat (3) tick();
    chk("zero_done", done_cnt, 1);
    chk("zero_beats", beat_cnt, 0);
    chk("zero_pops", pop_cnt, 0);
    if (done_cyc.size() == 1)
      chk("zero_done_lat", done_cyc[0] - (cyc - 3), 1);

    // oversized length
    for (int i = 0; i < 300; i++) fifo_q.push_back(32'h1000 + i);
    sync_fifo();
    rdy_mode = 1;
    clr_logs();
    send_cmd(MAXB + 5);
    wait_idle(3000);
    chk("big_beats", beat_cnt, 256);
    chk("big_left", fifo_q.size(), 44);
    chk("big_last_cnt", last_cnt, 1);
    chk("big_done", done_cnt, 1);
    if (beat_d.size() == 256)
      chk("big_last_data", beat_d[255], 32'h10FF);
    fifo_q.delete();
    sync_fifo();
    rdy_mode = 0;

    // reset mid-burst
    for (int i = 0; i < 8; i++) push(32'hC0 + i);
    tick();
    clr_logs();
    send_cmd(8);
    n = 0;
    while (beat_cnt < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("mid_reach_two", beat_cnt, 2);
    rst_n = 1'b0;
    tick();
    chk("mid_out_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_cmd_ready", cmd_ready, 1);
    chk("mid_no_done", done_cnt, 0);
    fifo_q.delete();
    sync_fifo();

    // command while busy
    for (int i = 0; i < 5; i++) push(32'hE0 + i);
    rdy_mode = 1;
    tick();
    clr_logs();
    send_cmd(5);
    cmd_valid = 1'b1;
    cmd_len = LW'(2);
    tick();
    chk("busy_cmd_ready", cmd_ready, 0);
    repeat (2) tick();
    cmd_valid = 1'b0;
    cmd_len = '0;
    wait_idle(200);
    repeat (5) tick();
    chk("busy_beats", beat_cnt, 5);
    chk("busy_done", done_cnt, 1);
    chk("busy_fifo_left", fifo_q.size(), 0);

    // randomized bursts
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(0, 12);
      pushed = $urandom_range(0, len);
      for (int i = 0; i < pushed; i++) push($urandom);
      rdy_mode = $urandom_range(0, 1);
      tick();
      clr_logs();
      send_cmd(len);
      n = 0;
      while ((m_busy || m_zero) && n < 500) begin
        tick();
        if (pushed < len && $urandom_range(0, 2) == 0) begin
          push($urandom);
          pushed++;
        end
        n++;
      end
      chk("rnd_timeout", {63'b0, m_busy}, 64'd0);
      chk("rnd_beats", beat_cnt, len);
      chk("rnd_done", done_cnt, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
